// File: rtl/alu_sequencer.sv
// alu_sequencer: program-driven initiator for the 8-bit registered ALU.
// Fetches 16-bit instructions, issues ALU ops, writes results back into R0..R7.
module alu_sequencer #(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_wdata,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_s,
  output logic        alu_en,
  input  logic [15:0] alu_y,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        carry_f,
  output logic        zero_f
);
  localparam int CW = $clog2(ALU_LAT + 1) + 1;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] WB    = 3'd4;
  logic [2:0]    state;
  logic [3:0]    pc;
  logic [15:0]   ir;
  logic [CW-1:0] cnt;
  logic [15:0]   prog [16];
  logic [7:0]    r [8];
  logic [2:0]    rd, rd_hi;
  logic          br_take;
  assign rd       = ir[9:7];
  assign rd_hi    = rd + 3'd1;
  assign dbg_data = r[dbg_addr];
  assign alu_en   = !busy;
  always_comb br_take = ir[13:12] == 2'b00 ? 1'b1 :
                        ir[13:12] == 2'b01 ? zero_f :
                        ir[13:12] == 2'b10 ? carry_f : !zero_f;
  // program memory survives reset so a reset run can restart the same code
  always_ff @(posedge clk)
    if (prog_we && !busy) prog[prog_addr] <= prog_wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_s   <= '0;
      carry_f <= 1'b0;
      zero_f  <= 1'b0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          pc    <= '0;
          busy  <= 1'b1;
        end
        FETCH: begin
          ir    <= prog[pc];
          state <= EXEC;
        end
        EXEC: case (ir[15:14])
          2'b00: begin
            alu_a <= r[ir[6:4]];
            alu_b <= r[ir[3:1]];
            alu_s <= ir[13:10];
            cnt   <= '0;
            state <= WAIT;
          end
          2'b01: begin
            r[ir[13:11]] <= ir[7:0];
            pc           <= pc + 4'd1;
            state        <= FETCH;
          end
          2'b10: begin
            pc    <= br_take ? ir[3:0] : pc + 4'd1;
            state <= FETCH;
          end
          default: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        endcase
        WAIT: if (cnt == CW'(ALU_LAT)) state <= WB;
              else cnt <= cnt + CW'(1);
        WB: begin
          r[rd] <= alu_y[7:0];
          if (ir[0]) r[rd_hi] <= alu_y[15:8];
          carry_f <= alu_carry;
          zero_f  <= alu_zero;
          pc      <= pc + 4'd1;
          state   <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench; stimulus queues expected end-of-program
// state, a monitor checks it whenever done pulses.
`timescale 1ns/1ps
module tb_alu_sequencer;
  typedef struct packed {
    logic [63:0] regs;
    logic        cf;
    logic        zf;
    logic [7:0]  lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_wdata = '0;
  logic [2:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_s;
  logic        alu_en;
  logic [15:0] alu_y = '0;
  logic        alu_carry = 1'b0, alu_zero = 1'b0;
  logic        carry_f, zero_f;
  int          checks = 0, errors = 0, cyc = 0, start_cyc = 0;
  exp_t        sb[$];

  alu_sequencer #(.ALU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_en(alu_en),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .carry_f(carry_f), .zero_f(zero_f)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in: 0 add, 1 sub, 4 mul (16-bit), 12 shift left; one register stage
  function automatic logic [17:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [15:0] y;
    logic        c;
    y = '0;
    c = 1'b0;
    case (s)
      4'd0:  {c, y[7:0]} = {1'b0, a} + {1'b0, b};
      4'd1:  begin y[7:0] = a - b; c = a < b; end
      4'd4:  y = {8'h00, a} * {8'h00, b};
      4'd12: begin y[7:0] = {a[6:0], 1'b0}; c = a[7]; end
      default: ;
    endcase
    return {c, y == 16'h0, y};
  endfunction
  always @(posedge clk) {alu_carry, alu_zero, alu_y} <= alu_f(alu_a, alu_b, alu_s);

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {2'b01, rd, 3'b000, imm};
  endfunction
  function automatic logic [15:0] aluop(input logic [3:0] s, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb, input logic w);
    return {2'b00, s, rd, ra, rb, w};
  endfunction
  function automatic logic [15:0] br(input logic [1:0] c, input logic [3:0] t);
    return {2'b10, c, 8'h00, t};
  endfunction
  localparam logic [15:0] HALT = 16'hC000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = a;
    prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic go(input bit push, input exp_t e, input bit disturb);
    bit got;
    if (push) sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    start_cyc = cyc;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = done;
      if (disturb && busy) chk("alu_en_busy", alu_en, 0);
      if (disturb && n == 3) begin
        start = 1'b1;
        prog_we = 1'b1;
        prog_addr = 4'd3;
        prog_wdata = ldi(3'd7, 8'h77);
      end else begin
        start = 1'b0;
        prog_we = 1'b0;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_s1();
    wr(4'd0, ldi(3'd1, 8'h05));
    wr(4'd1, ldi(3'd2, 8'h03));
    wr(4'd2, aluop(4'd0, 3'd3, 3'd1, 3'd2, 1'b0));
    wr(4'd3, HALT);
  endtask

  // monitor: on each done pulse compare timing, status and every register
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("latency", cyc - start_cyc, 32'(e.lat));
        chk("busy_at_done", busy, 0);
        chk("alu_en_idle", alu_en, 1);
        chk("carry_f", carry_f, e.cf);
        chk("zero_f", zero_f, e.zf);
        for (int i = 0; i < 8; i++) begin
          dbg_addr = 3'(i);
          #1;
          chk($sformatf("R%0d", i), dbg_data, e.regs[i*8 +: 8]);
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_en", alu_en, 1);
    chk("rst_alu_abs", {alu_a, alu_b, alu_s}, 0);
    chk("rst_flags", {carry_f, zero_f}, 0);
    @(negedge clk) rst_n = 1'b1;

    load_s1();
    go(1, exp_t'{64'h00000000_08030500, 1'b0, 1'b0, 8'd12}, 0);

    wr(4'd0, ldi(3'd1, 8'hFF));
    wr(4'd1, ldi(3'd2, 8'hFF));
    wr(4'd2, aluop(4'd4, 3'd4, 3'd1, 3'd2, 1'b1));
    wr(4'd3, aluop(4'd4, 3'd7, 3'd1, 3'd2, 1'b1));
    wr(4'd4, HALT);
    go(1, exp_t'{64'h0100FE01_08FFFFFE, 1'b0, 1'b0, 8'd18}, 0);

    wr(4'd0, ldi(3'd1, 8'h81));
    wr(4'd1, aluop(4'd12, 3'd1, 3'd1, 3'd1, 1'b0));
    wr(4'd2, br(2'b10, 4'd9));
    wr(4'd3, ldi(3'd6, 8'hBB));
    wr(4'd4, HALT);
    wr(4'd9, ldi(3'd6, 8'h99));
    wr(4'd10, HALT);
    go(1, exp_t'{64'h0199FE01_08FF02FE, 1'b1, 1'b0, 8'd14}, 0);

    wr(4'd0, ldi(3'd1, 8'h05));
    wr(4'd1, aluop(4'd1, 3'd3, 3'd1, 3'd1, 1'b0));
    wr(4'd2, br(2'b11, 4'd8));
    wr(4'd3, ldi(3'd2, 8'h22));
    wr(4'd4, br(2'b01, 4'd6));
    wr(4'd5, ldi(3'd4, 8'hEE));
    wr(4'd6, ldi(3'd5, 8'h55));
    wr(4'd7, HALT);
    wr(4'd8, ldi(3'd4, 8'h44));
    wr(4'd9, HALT);
    go(1, exp_t'{64'h01995501_002205FE, 1'b0, 1'b1, 8'd18}, 0);

    // abort during WAIT, then rerun the untouched program
    load_s1();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_alu_en", alu_en, 1);
    chk("abort_alu_abs", {alu_a, alu_b, alu_s}, 0);
    chk("abort_flags", {carry_f, zero_f}, 0);
    @(negedge clk) rst_n = 1'b1;
    go(1, exp_t'{64'h00000000_08030500, 1'b0, 1'b0, 8'd12}, 0);

    go(1, exp_t'{64'h00000000_08030500, 1'b0, 1'b0, 8'd12}, 1);
    chk("idle_alu_en", alu_en, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator-side controller for the team's 8-bit registered ALU: holds a 16-entry program and an 8x8-bit register file.
- Fetches and decodes instructions, drives ALU operands and opcode, waits out the ALU pipeline, and captures y/carry/zero back into registers and flag bits.
- Supports immediate loads, conditional branches and halt, so ALU sequences run without a testbench driving every cycle.

Parameters:
ALU_LAT, 2, ALU pipeline slack in cycles; minimum legal value 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin execution at PC=0 (ignored while busy)
busy  out  1  high from accepted start until halt
done  out  1  one-cycle pulse when HALT completes
prog_we  in  1  program write strobe (ignored while busy)
prog_addr  in  4  program write address
prog_wdata  in  16  instruction word
dbg_addr  in  3  register readback address
dbg_data  out  8  combinational R[dbg_addr]
alu_a  out  8  ALU operand a (registered)
alu_b  out  8  ALU operand b (registered)
alu_s  out  4  ALU select (registered)
alu_en  out  1  ALU en: 0 while busy, 1 otherwise (holds ALU cleared)
alu_y  in  16  ALU result
alu_carry  in  1  ALU carry flag
alu_zero  in  1  ALU zero flag
carry_f  out  1  sequencer carry flag
zero_f  out  1  sequencer zero flag

Behaviour:
- Reset (async, rst_n low):
  - Outputs: busy=0, done=0, alu_a=alu_b=0, alu_s=0, alu_en=1, carry_f=zero_f=0.
  - Internal: R0..R7=0, PC=0, state=IDLE.
  - Program memory is not reset and keeps its contents.
- Instruction format, keyed on [15:14]:
  - 00 ALU: s=[13:10], rd=[9:7], ra=[6:4], rb=[3:1], wide=[0].
  - 01 LDI: rd=[13:11], imm=[7:0].
  - 10 BR: cond=[13:12] (00 always, 01 zero_f, 10 carry_f, 11 !zero_f), target=[3:0].
  - 11 HALT.
- FSM states and transitions:
  - IDLE: on start go to FETCH with PC=0; busy rises the cycle after start.
  - FETCH (1 cycle): IR <= prog[PC].
  - EXEC (1 cycle):
    - LDI: R[rd] <= imm, PC+1, go to FETCH.
    - BR: PC <= target if cond true, else PC+1, go to FETCH.
    - HALT: go to IDLE, busy=0, done=1 for one cycle.
    - ALU: alu_a <= R[ra], alu_b <= R[rb], alu_s <= s, go to WAIT.
  - WAIT: exactly ALU_LAT+1 cycles, then WB.
  - WB (1 cycle):
    - R[rd] <= alu_y[7:0].
    - If wide: R[(rd+1) mod 8] <= alu_y[15:8]; rd=7 wraps to R0.
    - carry_f <= alu_carry, zero_f <= alu_zero.
    - PC+1, go to FETCH.
- Cycle counts: LDI/BR/HALT take 2 cycles; ALU ops take ALU_LAT+4 cycles.
- Operand hold: alu_a/alu_b/alu_s hold their values until the next ALU EXEC.
- PC: 4-bit, sequential increment wraps 15->0. No loop watchdog; an infinite loop runs until reset.
- Flags: only ALU WB updates carry_f/zero_f. LDI and BR leave them unchanged.
- Results: alu_y is written as received; divide-by-zero results are whatever the ALU returns (don't-care for checking).
- Ignored inputs:
  - start while busy.
  - prog_we while busy.
  - start in the same cycle as done, which takes effect only from IDLE on the next cycle.
- If wide writes R[rd+1] with rd+1==ra, the new value applies to later instructions only.
- Reset mid-operation aborts immediately; the next start reruns from PC=0.

Test Plan:
- Program LDI R1,0x05; LDI R2,0x03; ALU s=0 rd=3 ra=1 rb=2; HALT; start -> R3=0x08, carry_f=0, zero_f=0, done pulses 12 cycles after start sampled, busy low after.
- R1=0xFF, R2=0xFF, ALU s=4 wide rd=4 -> R4=0x01, R5=0xFE; repeat with rd=7 -> R7=0x01, R0=0xFE.
- R1=0x81, ALU s=12 rd=1 ra=1 -> R1=0x02, carry_f=1; following BR cond=10 target=9 lands PC=9, verified by an LDI marker at addr 9.
- ALU s=1 rd=3 ra=1 rb=1 -> R3=0x00, zero_f=1; BR cond=11 not taken, BR cond=01 taken; an LDI between them leaves flags unchanged.
- Drop rst_n during WAIT -> busy=0, alu_en=1, all regs 0, flags 0 asynchronously; program intact; new start reproduces the first scenario's result.
- Pulse start and prog_we mid-run -> no restart, program memory unchanged; alu_en=0 throughout the run and 1 in IDLE.
